bus_router: RTL
===============

// Module: bus_router
// PURPOSE
//  Parametrised memory-map router between the arbiter's single memory port and NSLV slave channels.
//  Successor to the flat testbench address decode. Adds:
//   - per-channel address windows;
//   - response steering only from the latched, selected channel;
//   - an error response for unmapped addresses;
//   - a response timeout.
//  Tracks one outstanding transaction; sits between arbiter and rom/print/clint/tim/ram.
// PARAMETERS
//  NSLV     6                 number of slave channels (1..16)
//  AW       32                address width
//  DW       32                data width; strobe width SW = DW/8
//  BASE     configure::*      NSLV x AW packed array, inclusive window base per channel
//  TOP      configure::*      NSLV x AW packed array, exclusive window top per channel
//  TIMEOUT  1024              cycles from issue to forced error response; 0 disables timeout
// PORTS
//  clock         in   1         rising-edge clock
//  reset         in   1         asynchronous, active-low reset
//  memory_valid  in   1         request strobe from arbiter (one-cycle pulse)
//  memory_instr  in   1         instruction-fetch qualifier
//  memory_addr   in   AW        request address
//  memory_wdata  in   DW        write data
//  memory_wstrb  in   SW        byte strobes; all-zero = read
//  memory_rdata  out  DW        response data
//  memory_ready  out  1         response strobe (one cycle)
//  memory_error  out  1         qualifies memory_ready: unmapped address or timeout
//  slv_valid     out  NSLV      per-channel request strobe
//  slv_instr     out  1         broadcast to all channels
//  slv_addr      out  AW        broadcast; equals memory_addr - BASE[sel]
//  slv_wdata     out  DW        broadcast
//  slv_wstrb     out  SW        broadcast
//  slv_rdata     in   NSLV x DW per-channel read data
//  slv_ready     in   NSLV      per-channel response strobe
//  stray_ready   out  1         sticky: a ready arrived from a non-selected channel
// BEHAVIOUR
//  Reset (reset=0, async): state=IDLE, sel=0, timer=0, slv_valid=0, memory_ready=0,
//   memory_error=0, memory_rdata=0, stray_ready=0.
//  Decode (combinational):
//   - channel i hits if BASE[i] <= addr < TOP[i]; lowest index wins on overlap.
//   - a miss leaves slv_valid=0 and slv_addr=memory_addr.
//  States:
//   - IDLE, memory_valid & hit: slv_valid[i]=1 in the same cycle (zero added latency);
//     latch sel=i, clear timer, go to BUSY.
//   - IDLE, memory_valid & miss: go to ERR; nothing forwarded.
//   - BUSY: memory_ready = slv_ready[sel]; memory_rdata = slv_rdata[sel]; memory_error=0.
//     Other channels' ready/rdata are ignored; any other slv_ready sets stray_ready.
//     On slv_ready[sel], go to IDLE.
//   - BUSY, timer reaches TIMEOUT-1 without ready: go to ERR.
//     A late ready from that slave is then ignored and sets stray_ready.
//   - ERR: memory_ready=1, memory_error=1, memory_rdata=0 for exactly one cycle; go to IDLE.
//  Back-to-back: memory_valid in the cycle memory_ready=1 (BUSY or ERR exit) is decoded
//   and accepted as if in IDLE.
//  memory_valid in BUSY without memory_ready is a protocol violation:
//   ignored, not forwarded, no state change.
//  Timer: log2(TIMEOUT)+1 bits, saturating, never wraps.
//  Address subtraction is AW-bit modulo. A hit guarantees no underflow.
//  Reset mid-transaction aborts it with no response; a late slave ready after reset
//   sets stray_ready.
// STRUCTURE
//  configure package:
//   - SLV_NUM;
//   - slv_base/slv_top constant arrays, built from the existing *_base_addr/*_top_addr constants;
//   - typedef enum {IDLE,BUSY,ERR} router_state_t.
//  One sub-module, addr_decode: combinational; addr -> hit, onehot[NSLV], idx, base.
//   Reusable by other interconnects.
//  bus_router holds the FSM, sel/timer registers and response mux.
// TESTING
//  1 Read ram: valid, addr=ram_base+0x10, wstrb=0 -> slv_valid[ram] same cycle,
//    slv_addr=0x10; ready 3 cycles later with 0xDEADBEEF -> memory_rdata=0xDEADBEEF, error=0.
//  2 Unmapped: addr=0xFFFF_FFF0 -> no slv_valid; next cycle ready=1, error=1, rdata=0.
//  3 Timeout, TIMEOUT=16: dtim never responds -> ready=1, error=1 exactly 16 cycles after issue;
//    dtim ready at cycle 20 -> stray_ready=1, no second memory_ready.
//  4 Steering: while BUSY on clint, rom asserts ready with 0x1234 -> memory_ready stays 0,
//    stray_ready=1; clint ready with 0x5 -> rdata=0x5.
//  5 Back-to-back: new valid to print in the cycle ram's ready returns -> slv_valid[print] that
//    cycle, both responses delivered in order.
//  6 Reset pulse in BUSY -> all outputs 0 immediately; next request to itim completes normally.

Source files
------------

// File: rtl/bus_router_pkg.sv
// Memory map and shared types for the bus router and its address decoder.
// The slave order fixes the decode priority: lower index wins on overlap.
package bus_router_pkg;

  localparam int SLV_NUM = 6;

  localparam int ROM_IDX   = 0;
  localparam int ITIM_IDX  = 1;
  localparam int DTIM_IDX  = 2;
  localparam int PRINT_IDX = 3;
  localparam int CLINT_IDX = 4;
  localparam int RAM_IDX   = 5;

  localparam logic [31:0] ROM_BASE_ADDR   = 32'h0000_0000;
  localparam logic [31:0] ROM_TOP_ADDR    = 32'h0001_0000;
  localparam logic [31:0] ITIM_BASE_ADDR  = 32'h1000_0000;
  localparam logic [31:0] ITIM_TOP_ADDR   = 32'h1000_4000;
  localparam logic [31:0] DTIM_BASE_ADDR  = 32'h2000_0000;
  localparam logic [31:0] DTIM_TOP_ADDR   = 32'h2000_4000;
  localparam logic [31:0] PRINT_BASE_ADDR = 32'h3000_0000;
  localparam logic [31:0] PRINT_TOP_ADDR  = 32'h3000_0010;
  localparam logic [31:0] CLINT_BASE_ADDR = 32'h0200_0000;
  localparam logic [31:0] CLINT_TOP_ADDR  = 32'h0200_C000;
  localparam logic [31:0] RAM_BASE_ADDR   = 32'h8000_0000;
  localparam logic [31:0] RAM_TOP_ADDR    = 32'h8010_0000;

  // Element [0] is the rightmost entry of each concatenation.
  localparam logic [SLV_NUM-1:0][31:0] SLV_BASE = {
    RAM_BASE_ADDR, CLINT_BASE_ADDR, PRINT_BASE_ADDR,
    DTIM_BASE_ADDR, ITIM_BASE_ADDR, ROM_BASE_ADDR
  };
  localparam logic [SLV_NUM-1:0][31:0] SLV_TOP = {
    RAM_TOP_ADDR, CLINT_TOP_ADDR, PRINT_TOP_ADDR,
    DTIM_TOP_ADDR, ITIM_TOP_ADDR, ROM_TOP_ADDR
  };

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    ERR  = 2'd2
  } router_state_t;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bus_router_addr_decode.sv
// Combinational window decoder: maps an address onto at most one channel,
// lowest index winning where windows overlap.
module addr_decode
  import bus_router_pkg::*;
#(
  parameter int                         NSLV = SLV_NUM,
  parameter int                         AW   = 32,
  parameter logic [NSLV-1:0][AW-1:0]    BASE = SLV_BASE,
  parameter logic [NSLV-1:0][AW-1:0]    TOP  = SLV_TOP,
  localparam int                        IW   = idx_width(NSLV)
) (
  input  logic [AW-1:0]   addr,
  output logic            hit,
  output logic [NSLV-1:0] onehot,
  output logic [IW-1:0]   idx,
  output logic [AW-1:0]   base
);

  // Scan from the top index down so the lowest matching window is the last writer.
  always_comb begin
    hit  = 1'b0;
    idx  = {IW{1'b0}};
    base = {AW{1'b0}};
    for (int i = NSLV - 1; i >= 0; i--) begin
      if ((addr >= BASE[i]) && (addr < TOP[i])) begin
        hit  = 1'b1;
        idx  = IW'(i);
        base = BASE[i];
      end else begin
        hit  = hit;
      end
    end
    if (hit) begin
      onehot = {{(NSLV-1){1'b0}}, 1'b1} << idx;
    end else begin
      onehot = {NSLV{1'b0}};
    end
  end

endmodule

// File: rtl/bus_router.sv
// Memory-map router: one outstanding transaction from the arbiter port to a
// selected slave channel, with unmapped-address and timeout error responses.
module bus_router
  import bus_router_pkg::*;
#(
  parameter int                         NSLV    = SLV_NUM,
  parameter int                         AW      = 32,
  parameter int                         DW      = 32,
  parameter logic [NSLV-1:0][AW-1:0]    BASE    = SLV_BASE,
  parameter logic [NSLV-1:0][AW-1:0]    TOP     = SLV_TOP,
  parameter int                         TIMEOUT = 1024,
  localparam int                        SW      = DW / 8
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      memory_valid,
  input  logic                      memory_instr,
  input  logic [AW-1:0]             memory_addr,
  input  logic [DW-1:0]             memory_wdata,
  input  logic [SW-1:0]             memory_wstrb,
  output logic [DW-1:0]             memory_rdata,
  output logic                      memory_ready,
  output logic                      memory_error,
  output logic [NSLV-1:0]           slv_valid,
  output logic                      slv_instr,
  output logic [AW-1:0]             slv_addr,
  output logic [DW-1:0]             slv_wdata,
  output logic [SW-1:0]             slv_wstrb,
  input  logic [NSLV-1:0][DW-1:0]   slv_rdata,
  input  logic [NSLV-1:0]           slv_ready,
  output logic                      stray_ready
);

  localparam int IW   = idx_width(NSLV);
  localparam int TW   = idx_width(TIMEOUT) + 1;
  // The timer is cleared on the issue edge, so stopping at TIMEOUT-2 puts the
  // error response exactly TIMEOUT cycles after the issuing cycle.
  localparam int             TLIM   = (TIMEOUT > 1) ? (TIMEOUT - 2) : 0;
  localparam logic [TW-1:0]  TLIM_V = TW'(TLIM);
  localparam bit             TO_EN  = (TIMEOUT != 0);

  router_state_t   state_r, state_s;
  logic [IW-1:0]   sel_r;
  logic [TW-1:0]   timer_r;
  logic            stray_r;

  logic            hit_s;
  logic [NSLV-1:0] onehot_s;
  logic [IW-1:0]   idx_s;
  logic [AW-1:0]   base_s;
  logic            accept_s;
  logic            timeout_s;
  logic            sel_ready_s;
  logic [NSLV-1:0] sel_mask_s;

  addr_decode #(
    .NSLV (NSLV),
    .AW   (AW),
    .BASE (BASE),
    .TOP  (TOP)
  ) u_decode (
    .addr   (memory_addr),
    .hit    (hit_s),
    .onehot (onehot_s),
    .idx    (idx_s),
    .base   (base_s)
  );

  assign slv_instr   = memory_instr;
  assign slv_wdata   = memory_wdata;
  assign slv_wstrb   = memory_wstrb;
  assign slv_addr    = memory_addr - base_s;
  assign stray_ready = stray_r;

  assign sel_ready_s = slv_ready[sel_r];
  assign timeout_s   = TO_EN && (timer_r >= TLIM_V);
  assign sel_mask_s  = (state_r == BUSY) ? ({{(NSLV-1){1'b0}}, 1'b1} << sel_r)
                                         : {NSLV{1'b0}};

  // Next state, response mux and zero-latency request forwarding.
  always_comb begin
    state_s      = state_r;
    memory_ready = 1'b0;
    memory_error = 1'b0;
    memory_rdata = {DW{1'b0}};
    case (state_r)
      IDLE: begin
        state_s = IDLE;
      end
      BUSY: begin
        memory_ready = sel_ready_s;
        memory_rdata = slv_rdata[sel_r];
        if (sel_ready_s) begin
          state_s = IDLE;
        end else if (timeout_s) begin
          state_s = ERR;
        end else begin
          state_s = BUSY;
        end
      end
      ERR: begin
        memory_ready = 1'b1;
        memory_error = 1'b1;
        state_s      = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase

    accept_s = memory_valid && ((state_r == IDLE) || memory_ready);
    if (accept_s) begin
      state_s = hit_s ? BUSY : ERR;
    end else begin
      state_s = state_s;
    end

    if (accept_s && hit_s) begin
      slv_valid = onehot_s;
    end else begin
      slv_valid = {NSLV{1'b0}};
    end
  end

  // State, selected channel, saturating timer and sticky stray flag.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r <= IDLE;
      sel_r   <= {IW{1'b0}};
      timer_r <= {TW{1'b0}};
      stray_r <= 1'b0;
    end else begin
      state_r <= state_s;
      stray_r <= stray_r | (|(slv_ready & ~sel_mask_s));
      if (accept_s && hit_s) begin
        sel_r   <= idx_s;
        timer_r <= {TW{1'b0}};
      end else if ((state_r == BUSY) && (timer_r != {TW{1'b1}})) begin
        timer_r <= timer_r + {{(TW-1){1'b0}}, 1'b1};
      end else begin
        timer_r <= timer_r;
      end
    end
  end

endmodule
